yrv_mem_resp: RTL and testbench
===============================

Name: yrv_mem_resp

Overview:
Memory-bus responder (slave) for the yrv_cpu memory interface. It accepts pipelined address phases from the CPU, inserts programmable wait states, performs byte-lane writes into a local word-wide SRAM and returns read data on mem_rdata. It sits between the CPU memory port and the on-chip instruction/data RAM. It is the reference target for every CPU bus-timing test.

Parameters:
AW, 12, word-address bits of local RAM (depth = 2**AW words)
BASE, 32'h0000_0000, byte base address of the RAM window (aligned to 4*2**AW)
RD_WAIT, 0, wait states inserted per read data phase (0..7)
WR_WAIT, 0, wait states inserted per write data phase (0..7)

Ports:
clk  input  1  bus clock
reset  input  1  asynchronous, active-high reset
mem_trans  input  2  transfer type of address phase: 00 idle, 01 fetch, 10 data, 11 data
mem_addr  input  32  byte address (address phase)
mem_write  input  1  write when 1 (address phase)
mem_ble  input  4  byte lane enables (address phase)
mem_lock  input  1  locked read-modify-write in progress
mem_wdata  input  32  write data (data phase)
mem_ready  output  1  data phase complete / next address phase accepted
mem_rdata  output  32  read data (valid in data phase while mem_ready=1)
mem_hit  output  1  registered: current data phase addresses the RAM window

Behaviour:
- Reset values: mem_ready=1, mem_rdata=0, mem_hit=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Pipelined protocol: an address phase is accepted at the rising edge where mem_ready=1 and mem_trans!=00. Its data phase occupies the following cycle(s). mem_ready=0 stretches the current data phase and holds off the next address phase, so the CPU keeps its address-phase outputs stable.
- Accept captures addr[AW+1:2], write, ble and hit into data-phase registers. hit = (mem_addr & ~(4*2**AW-1)) == BASE.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counter nonzero, mem_ready=0.
  - DATA: mem_ready=1, data phase completes this cycle.
- FSM transitions:
  - From IDLE or DATA: on accept, go to WAIT with count = (write ? WR_WAIT : RD_WAIT) when that value is nonzero, else go straight to DATA. With no accept, go to IDLE.
  - From WAIT: decrement the counter. Go to DATA when the counter reaches 1.
- Locked RMW: when mem_lock=1 at accept of a write, WR_WAIT is skipped (count 0) so the read/write pair is atomic to the bus.
- Read data path: RAM read is synchronous. The address is registered at accept, or re-read on the last WAIT cycle, so that mem_rdata = RAM[word] during the DATA cycle. With zero wait, read latency is exactly one cycle after accept. mem_rdata holds its last value outside DATA.
- Reads outside the window (hit=0) return 32'h0.
- Write path: at the DATA cycle edge, when write=1 and hit=1, RAM[word] byte n <= mem_wdata byte n for each ble[n]=1. Writes with ble=0000 and writes with hit=0 leave the RAM unchanged.
- Back-to-back transfers: a new address phase may be accepted in the same cycle as the current DATA. A read immediately following a write to the same word returns the newly written data: bypass from the write registers, byte-merged per ble.
- Address-phase fields are ignored when mem_trans=00. A fetch (01) is treated as a read regardless of mem_write.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, mem_ready=1, and any in-flight write is discarded.

Decomposition:
- Shared package yrv_mem_pkg holds:
  - transfer-type constants TRANS_IDLE/FETCH/DATA
  - FSM state encodings
  - lane-merge function (old word, new word, ble)
- One sub-module, yrv_mem_ram: single-port synchronous RAM, 2**AW x 32, with per-byte write enables. It is the only block to be swapped for vendor macros.
- Control FSM, wait counter, window decode and bypass stay in yrv_mem_resp.

Test Plan:
- Reset then idle: reset=1 for 3 cycles -> mem_ready=1, mem_rdata=0, mem_hit=0; stays so with mem_trans=00.
- Zero-wait read (RD_WAIT=0): preload RAM[0x10]=32'hDEADBEEF, fetch addr 0x40 -> next cycle mem_ready=1, mem_rdata=32'hDEADBEEF, mem_hit=1.
- Byte write then read: write addr 0x44 ble=0110 wdata=32'h11223344 over 32'hAABBCCDD, then an immediate back-to-back read -> 32'hAA2233DD (bypass), and the same value on a later non-adjacent read.
- Wait states (RD_WAIT=2, WR_WAIT=3): read -> mem_ready low for exactly 2 cycles then 1 DATA cycle; write -> low 3 cycles. A second address phase held during the stall is accepted only on the DATA edge.
- Locked RMW (WR_WAIT=3, mem_lock=1): read then write to the same address -> write completes with zero wait states, memory updated.
- Out of window plus mid-transfer reset: read at BASE+4*2**AW -> rdata=0, hit=0; write there -> RAM unchanged. Assert reset during a WAIT cycle -> mem_ready=1 immediately and the pending write is not performed.

Source files
------------

// File: rtl/yrv_mem_pkg.sv
// yrv_mem_pkg: shared definitions for the yrv_cpu memory responder.
//   - transfer-type encodings driven on mem_trans
//   - control FSM state encoding
//   - lane_merge(): byte-lane merge of a new word over an old word
package yrv_mem_pkg;

   localparam logic [1:0] TRANS_IDLE  = 2'b00;
   localparam logic [1:0] TRANS_FETCH = 2'b01;
   localparam logic [1:0] TRANS_DATA  = 2'b10;   // 2'b11 is also a data transfer

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no data phase pending
      ST_WAIT = 2'd1,   // stalling, mem_ready = 0
      ST_DATA = 2'd2    // data phase completes this cycle
   } state_e;

   // Each byte n comes from new_w when ble[n] is set, otherwise from old_w.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  ble);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (ble[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/yrv_mem_ram.sv
// yrv_mem_ram: single-port synchronous RAM, 2**AW x 32, per-byte write enables.
// This is the block to replace with a vendor macro.
//   clk      : clock
//   en_i     : port enable (read when we_i=0, write when we_i=1)
//   we_i     : write strobe
//   be_i     : byte enables for writes
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : read data, updated one cycle after a read; holds otherwise
module yrv_mem_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [2**AW];
   logic [31:0] rdata_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < 4; i++) begin
               if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/yrv_mem_resp.sv
// yrv_mem_resp: pipelined memory-bus responder for the yrv_cpu memory port.
// Accepts address phases, inserts RD_WAIT / WR_WAIT wait states, writes byte
// lanes into a local RAM and returns read data in the data phase.
//   clk, reset : clock, asynchronous active-high reset
//   mem_trans  : 00 idle, 01 fetch, 1x data (address phase)
//   mem_addr   : byte address (address phase)
//   mem_write  : write strobe (address phase, ignored for fetch)
//   mem_ble    : byte lane enables (address phase)
//   mem_lock   : locked RMW; a locked write skips its wait states
//   mem_wdata  : write data (data phase)
//   mem_ready  : data phase complete / next address phase accepted
//   mem_rdata  : read data during a read DATA cycle, holds otherwise
//   mem_hit    : current data phase addresses the RAM window
//
// The RAM has a single port. A zero-wait read accepted on the same edge a
// write completes needs the port for the read, so that write is parked in a
// one-entry write buffer and retired on the next edge with a free port.
// Reads merge the buffer over the RAM word when the words match. The buffer is
// always empty again by the next write's DATA edge, because a write's accept
// edge never issues a RAM read.
module yrv_mem_resp
   import yrv_mem_pkg::*;
#(
   parameter int          AW      = 12,
   parameter logic [31:0] BASE    = 32'h0000_0000,
   parameter int          RD_WAIT = 0,
   parameter int          WR_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_trans,
   input  logic [31:0] mem_addr,
   input  logic        mem_write,
   input  logic [3:0]  mem_ble,
   input  logic        mem_lock,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_hit
);

   localparam logic [2:0]  RD_W     = 3'(RD_WAIT);
   localparam logic [2:0]  WR_W     = 3'(WR_WAIT);
   localparam logic [31:0] WIN_MASK = ~((32'd4 << AW) - 32'd1);

   state_e        state_q;
   logic          ready_q;
   logic [2:0]    cnt_q;
   logic [AW-1:0] word_q;
   logic          write_q;
   logic [3:0]    ble_q;
   logic          hit_q;
   logic [31:0]   rdata_q;
   logic          wb_valid_q;
   logic [AW-1:0] wb_word_q;
   logic [31:0]   wb_data_q;
   logic [3:0]    wb_ble_q;

   // Address-phase decode
   logic          accept;
   logic          acc_write;
   logic [2:0]    acc_wait;
   logic [AW-1:0] acc_word;
   logic          acc_hit;

   assign accept    = ready_q && (mem_trans != TRANS_IDLE);
   assign acc_write = mem_trans[1] && mem_write;   // a fetch is always a read
   assign acc_wait  = acc_write ? (mem_lock ? 3'd0 : WR_W) : RD_W;
   assign acc_word  = mem_addr[AW+1:2];
   assign acc_hit   = (mem_addr & WIN_MASK) == BASE;

   // RAM port arbitration: read issue > completing write > buffer drain
   logic          rd_issue;
   logic          wr_done;
   logic          wr_direct;
   logic          wb_drain;
   logic          ram_en;
   logic          ram_we;
   logic [3:0]    ram_be;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   // A read hits the RAM at accept (zero wait) or on its last WAIT edge, so
   // the RAM output is valid exactly in the DATA cycle.
   assign rd_issue  = (accept && !acc_write && (acc_wait == 3'd0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 3'd1) && !write_q);
   assign wr_done   = (state_q == ST_DATA) && write_q && hit_q && (ble_q != 4'b0000);
   assign wr_direct = wr_done && !rd_issue;
   assign wb_drain  = wb_valid_q && !rd_issue && !wr_done;
   assign ram_we    = wr_direct || wb_drain;
   assign ram_en    = rd_issue || ram_we;
   assign ram_be    = wr_direct ? ble_q : wb_ble_q;
   assign ram_wdata = wr_direct ? mem_wdata : wb_data_q;

   always_comb begin
      ram_addr = wb_word_q;
      if (rd_issue)       ram_addr = (state_q == ST_WAIT) ? word_q : acc_word;
      else if (wr_direct) ram_addr = word_q;
   end

   yrv_mem_ram #(.AW(AW)) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // Control FSM and data-phase registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         cnt_q   <= 3'd0;
         word_q  <= '0;
         write_q <= 1'b0;
         ble_q   <= 4'b0000;
         hit_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DATA: begin
               if (accept) begin
                  word_q  <= acc_word;
                  write_q <= acc_write;
                  ble_q   <= mem_ble;
                  hit_q   <= acc_hit;
                  cnt_q   <= acc_wait;
                  if (acc_wait != 3'd0) begin
                     state_q <= ST_WAIT;
                     ready_q <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                     ready_q <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_q <= ST_DATA;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Read data: out-of-window reads return zero; a pending buffered write to
   // the same word is merged over the (stale) RAM word.
   logic        rd_phase;
   logic [31:0] rd_live;

   assign rd_phase = (state_q == ST_DATA) && !write_q;

   always_comb begin
      rd_live = 32'h0;
      if (hit_q) begin
         if (wb_valid_q && (wb_word_q == word_q))
            rd_live = lane_merge(ram_rdata, wb_data_q, wb_ble_q);
         else
            rd_live = ram_rdata;
      end
   end

   // Reset also drops a parked write, matching the discard of in-flight writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q    <= 32'h0;
         wb_valid_q <= 1'b0;
         wb_word_q  <= '0;
         wb_data_q  <= 32'h0;
         wb_ble_q   <= 4'b0000;
      end else begin
         if (rd_phase) rdata_q <= rd_live;
         if (wr_done && rd_issue) begin
            wb_valid_q <= 1'b1;
            wb_word_q  <= word_q;
            wb_data_q  <= mem_wdata;
            wb_ble_q   <= ble_q;
         end else if (wb_drain) begin
            wb_valid_q <= 1'b0;
         end
      end
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rd_phase ? rd_live : rdata_q;
   assign mem_hit   = hit_q;

endmodule

// File: tb/tb_yrv_mem_resp.sv
// Bench for yrv_mem_resp. Two instances share one bus driver: u_dut0 has zero
// wait states, u_dut1 has RD_WAIT=2 / WR_WAIT=3. 'sel' routes mem_trans to one
// instance (the other sees idle) and selects which outputs are observed.
module tb_yrv_mem_resp;
   import yrv_mem_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  trans;
   logic [31:0] addr;
   logic        write;
   logic [3:0]  ble;
   logic        lock;
   logic [31:0] wdata;
   logic        sel;

   logic [1:0]  trans0, trans1;
   logic        ready0, ready1, hit0, hit1;
   logic [31:0] rdata0, rdata1;
   logic        ready, hit;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   assign trans0 = sel ? TRANS_IDLE : trans;
   assign trans1 = sel ? trans : TRANS_IDLE;
   assign ready  = sel ? ready1 : ready0;
   assign rdata  = sel ? rdata1 : rdata0;
   assign hit    = sel ? hit1 : hit0;

   yrv_mem_resp #(.AW(12), .BASE(32'h0), .RD_WAIT(0), .WR_WAIT(0)) u_dut0 (
      .clk(clk), .reset(reset), .mem_trans(trans0), .mem_addr(addr),
      .mem_write(write), .mem_ble(ble), .mem_lock(lock), .mem_wdata(wdata),
      .mem_ready(ready0), .mem_rdata(rdata0), .mem_hit(hit0));

   yrv_mem_resp #(.AW(12), .BASE(32'h0), .RD_WAIT(2), .WR_WAIT(3)) u_dut1 (
      .clk(clk), .reset(reset), .mem_trans(trans1), .mem_addr(addr),
      .mem_write(write), .mem_ble(ble), .mem_lock(lock), .mem_wdata(wdata),
      .mem_ready(ready1), .mem_rdata(rdata1), .mem_hit(hit1));

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one address phase (assumes mem_ready=1), then its data phase.
   // Returns the read data and hit seen in the DATA cycle, and the number of
   // stall cycles (bounded at 20).
   task automatic bus_xfer(input logic [1:0] t, input logic [31:0] a,
                           input logic w, input logic [3:0] b, input logic lk,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic hv, output int stall);
      trans = t; addr = a; write = w; ble = b; lock = lk;
      tick();
      trans = TRANS_IDLE;
      wdata = wd;
      stall = 0;
      while (ready !== 1'b1 && stall < 20) begin
         tick();
         stall++;
      end
      rd = rdata;
      hv = hit;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      trans = TRANS_IDLE; addr = 32'h0; write = 1'b0; ble = 4'h0; lock = 1'b0;
      wdata = 32'h0; sel = 1'b0;
      repeat (3) tick();
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", ready0); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 00000000", rdata0); end
      checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL reset_hit0: got %b expected 0", hit0); end
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b expected 1", ready1); end
      reset = 1'b0;
      repeat (3) tick();
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL idle_ready0: got %b expected 1", ready0); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL idle_rdata0: got %h expected 00000000", rdata0); end
      checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL idle_hit0: got %b expected 0", hit0); end
   endtask

   task automatic test_zero_wait_read();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b0;
      bus_xfer(TRANS_DATA, 32'h40, 1'b1, 4'hF, 1'b0, 32'hDEADBEEF, rd, hv, st);
      checks++; if (st != 0) begin errors++; $display("FAIL zw_write_stall: got %0d expected 0", st); end
      // Fetch with mem_write=1 must still be a read
      bus_xfer(TRANS_FETCH, 32'h40, 1'b1, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (st != 0) begin errors++; $display("FAIL zw_read_stall: got %0d expected 0", st); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_read_data: got %h expected deadbeef", rd); end
      checks++; if (hv !== 1'b1) begin errors++; $display("FAIL zw_read_hit: got %b expected 1", hv); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rdata_hold: got %h expected deadbeef", rdata); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b0;
      bus_xfer(TRANS_DATA, 32'h44, 1'b1, 4'hF, 1'b0, 32'hAABBCCDD, rd, hv, st);
      // Partial write immediately followed by a read of the same word
      trans = TRANS_DATA; addr = 32'h44; write = 1'b1; ble = 4'b0110; lock = 1'b0;
      tick();
      wdata = 32'h11223344;
      trans = TRANS_DATA; addr = 32'h44; write = 1'b0; ble = 4'hF;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
      tick();
      trans = TRANS_IDLE;
      checks++; if (rdata !== 32'hAA2233DD) begin errors++; $display("FAIL b2b_bypass: got %h expected aa2233dd", rdata); end
      tick();
      bus_xfer(TRANS_DATA, 32'h40, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_other_word: got %h expected deadbeef", rd); end
      bus_xfer(TRANS_DATA, 32'h44, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'hAA2233DD) begin errors++; $display("FAIL b2b_later_read: got %h expected aa2233dd", rd); end
      // ble=0000 write leaves the word alone
      bus_xfer(TRANS_DATA, 32'h44, 1'b1, 4'h0, 1'b0, 32'hFFFFFFFF, rd, hv, st);
      bus_xfer(TRANS_DATA, 32'h44, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'hAA2233DD) begin errors++; $display("FAIL ble0_write: got %h expected aa2233dd", rd); end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b1;
      bus_xfer(TRANS_DATA, 32'h80, 1'b1, 4'hF, 1'b0, 32'h12345678, rd, hv, st);
      checks++; if (st != 3) begin errors++; $display("FAIL ws_write_stall: got %0d expected 3", st); end
      bus_xfer(TRANS_DATA, 32'h80, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (st != 2) begin errors++; $display("FAIL ws_read_stall: got %0d expected 2", st); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ws_read_data: got %h expected 12345678", rd); end
      // Second address phase held through the stall
      trans = TRANS_DATA; addr = 32'h80; write = 1'b0; ble = 4'hF;
      tick();
      trans = TRANS_FETCH; addr = 32'h80;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ws_hold_w1: got %b expected 0", ready); end
      tick();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ws_hold_w2: got %b expected 0", ready); end
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ws_hold_data1: got %b expected 1", ready); end
      checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL ws_hold_rdata1: got %h expected 12345678", rdata); end
      tick();
      trans = TRANS_IDLE;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ws_second_accept: got %b expected 0", ready); end
      tick();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ws_second_w2: got %b expected 0", ready); end
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ws_second_data: got %b expected 1", ready); end
      checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL ws_second_rdata: got %h expected 12345678", rdata); end
      tick();
   endtask

   task automatic test_locked_rmw();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b1;
      bus_xfer(TRANS_DATA, 32'h80, 1'b0, 4'hF, 1'b1, 32'h0, rd, hv, st);
      checks++; if (st != 2) begin errors++; $display("FAIL lock_read_stall: got %0d expected 2", st); end
      bus_xfer(TRANS_DATA, 32'h80, 1'b1, 4'hF, 1'b1, 32'hCAFEF00D, rd, hv, st);
      checks++; if (st != 0) begin errors++; $display("FAIL lock_write_stall: got %0d expected 0", st); end
      bus_xfer(TRANS_DATA, 32'h80, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL lock_result: got %h expected cafef00d", rd); end
   endtask

   task automatic test_out_of_window();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b0;
      bus_xfer(TRANS_DATA, 32'h0, 1'b1, 4'hF, 1'b0, 32'h0BADC0DE, rd, hv, st);
      bus_xfer(TRANS_DATA, 32'h4000, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oow_rdata: got %h expected 00000000", rd); end
      checks++; if (hv !== 1'b0) begin errors++; $display("FAIL oow_hit: got %b expected 0", hv); end
      bus_xfer(TRANS_DATA, 32'h4000, 1'b1, 4'hF, 1'b0, 32'hFFFFFFFF, rd, hv, st);
      bus_xfer(TRANS_DATA, 32'h0, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL oow_no_alias: got %h expected 0badc0de", rd); end
      checks++; if (hv !== 1'b1) begin errors++; $display("FAIL oow_inwin_hit: got %b expected 1", hv); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic hv; int st;
      sel = 1'b1;
      bus_xfer(TRANS_DATA, 32'h90, 1'b1, 4'hF, 1'b0, 32'h55AA55AA, rd, hv, st);
      trans = TRANS_DATA; addr = 32'h90; write = 1'b1; ble = 4'hF; lock = 1'b0;
      tick();
      trans = TRANS_IDLE;
      wdata = 32'h11111111;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got %b expected 0", ready); end
      tick();
      #2 reset = 1'b1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
      tick();
      tick();
      reset = 1'b0;
      checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_mid_hit: got %b expected 0", hit); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 00000000", rdata); end
      tick();
      bus_xfer(TRANS_DATA, 32'h90, 1'b0, 4'hF, 1'b0, 32'h0, rd, hv, st);
      checks++; if (st != 2) begin errors++; $display("FAIL rst_mid_read_stall: got %0d expected 2", st); end
      checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rst_mid_discard: got %h expected 55aa55aa", rd); end
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_back_to_back();
      test_wait_states();
      test_locked_rmw();
      test_out_of_window();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
